au_sequencer: RTL and testbench

Multi-cycle sequencer for the calculator's arithmetic unit. It accepts an operand pair and a 2-bit operation code from the control unit and executes the operation:
- add and subtract in one cycle;
- multiply as an iterative shift-add;
- divide as restoring division, one bit per cycle.

It reports completion to the control unit with a Busy/Done handshake, and it is the only writer of the result presented to the output unit.

---
 rtl/au_sequencer_if.sv | 25 ++
 rtl/au_sequencer.sv | 140 ++++++++++++++
 tb/tb_au_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/au_sequencer_if.sv
// Control-unit handshake bundle for the arithmetic-unit sequencer:
// request/operands toward the sequencer, result and status back.
interface au_sequencer_if #(
  parameter int WIDTH = 8
) ();
  logic                 start;
  logic [1:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   result;
  logic [WIDTH-1:0]     remainder;
  logic                 busy;
  logic                 done;
  logic                 divzero;

  modport master (
    output start, op, a, b,
    input  result, remainder, busy, done, divzero
  );

  modport slave (
    input  start, op, a, b,
    output result, remainder, busy, done, divzero
  );
endinterface

// File: rtl/au_sequencer.sv
// Arithmetic-unit sequencer: single-cycle add/sub, shift-add multiply and
// restoring divide (one bit per cycle) with a Busy/Done handshake.
module au_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  au_sequencer_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ITER} state_t;

  state_t               r_state, w_state_nxt;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_a, r_b;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [2*WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]     r_rem;
  logic                 r_busy, r_done, r_divzero;

  logic                 w_accept, w_finish, w_dz;
  logic [2*WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH:0]       w_sum, w_diff, w_mul_hi, w_div_sh;
  logic [WIDTH-1:0]     w_div_rem;
  logic                 w_div_ge;
  logic [2*WIDTH-1:0]   w_mul_nxt, w_div_nxt;

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  // Multiply: r_acc = {partial product high, multiplier bits still to consume}.
  assign w_mul_hi  = r_acc[0] ? ({1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a})
                              : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_mul_nxt = {w_mul_hi, r_acc[WIDTH-1:1]};

  // Divide: r_acc = {remainder, quotient}; the shifted remainder needs one extra bit.
  assign w_div_sh  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge  = (w_div_sh >= {1'b0, r_b});
  assign w_div_rem = w_div_sh[WIDTH-1:0] - r_b;
  assign w_div_nxt = w_div_ge ? {w_div_rem, r_acc[WIDTH-2:0], 1'b1}
                              : {w_div_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    w_res       = '0;
    w_rem       = '0;
    w_dz        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          if (bus.op == OP_MUL || (bus.op == OP_DIV && bus.b != '0)) w_state_nxt = S_ITER;
          else                                                       w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        w_finish    = 1'b1;
        w_state_nxt = S_IDLE;
        case (r_op)
          OP_ADD:  w_res = {{(WIDTH-1){1'b0}}, w_sum};
          OP_SUB:  w_res = {{(WIDTH-1){w_diff[WIDTH]}}, w_diff};
          default: begin
            w_res = '1;
            w_rem = r_a;
            w_dz  = 1'b1;
          end
        endcase
      end
      S_ITER: begin
        if (r_cnt == CW'(1)) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
          if (r_op == OP_DIV) begin
            w_res = {{WIDTH{1'b0}}, w_div_nxt[WIDTH-1:0]};
            w_rem = w_div_nxt[2*WIDTH-1:WIDTH];
          end else begin
            w_res = w_mul_nxt;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_rem     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op   <= bus.op;
        r_a    <= bus.a;
        r_b    <= bus.b;
        r_busy <= 1'b1;
        r_cnt  <= CW'(WIDTH);
        r_acc  <= (bus.op == OP_DIV) ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{1'b0}}, bus.b};
      end
      if (r_state == S_ITER) begin
        r_cnt <= r_cnt - CW'(1);
        r_acc <= (r_op == OP_DIV) ? w_div_nxt : w_mul_nxt;
      end
      if (w_finish) begin
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
        r_result  <= w_res;
        r_rem     <= w_rem;
        r_divzero <= w_dz;
      end
    end
  end

  assign bus.result    = r_result;
  assign bus.remainder = r_rem;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.divzero   = r_divzero;
endmodule

// File: tb/tb_au_sequencer.sv
// Scoreboard bench for au_sequencer: expected results are queued when a
// request is issued and compared when Done is seen.
module tb_au_sequencer;
  localparam int W = 8;

  typedef struct {
    logic [2*W-1:0] res;
    logic [W-1:0]   rem;
    logic           dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];
  logic [2*W-1:0] last_res = '0;

  always #5 clk = ~clk;

  au_sequencer_if #(.WIDTH(W)) bus ();
  au_sequencer #(.WIDTH(W)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t m;
    m.rem = '0;
    m.dz  = 1'b0;
    case (op)
      2'd0: m.res = {{W{1'b0}}, a} + {{W{1'b0}}, b};
      2'd1: m.res = {{W{1'b0}}, a} - {{W{1'b0}}, b};
      2'd2: m.res = (2*W)'(a) * (2*W)'(b);
      default: begin
        if (b == '0) begin
          m.res = '1;
          m.rem = a;
          m.dz  = 1'b1;
        end else begin
          m.res = {{W{1'b0}}, a / b};
          m.rem = a % b;
        end
      end
    endcase
    return m;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    if (push) sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4*W) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    #2;
    n_total++;
    if ({bus.result, bus.remainder, bus.busy, bus.done, bus.divzero} !== '0)
      $display("FAIL reset_outputs: got res=%h rem=%h busy=%b done=%b dz=%b, want all 0",
               bus.result, bus.remainder, bus.busy, bus.done, bus.divzero);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    else n_pass++;
  endtask

  task automatic test_add();
    logic [W-1:0] av[2] = '{8'd25, 8'd200};
    logic [W-1:0] bv[2] = '{8'd17, 8'd200};
    int cyc;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(2'd0, av[i], bv[i], 1'b1);
      wait_done(cyc);
      e = sb.pop_front();
      n_total++;
      if (cyc !== 1) $display("FAIL add_latency[%0d]: got %0d, want 1", i, cyc); else n_pass++;
      n_total++;
      if (bus.result !== e.res || bus.remainder !== e.rem || bus.divzero !== e.dz || bus.busy !== 1'b0)
        $display("FAIL add_result[%0d]: got res=%h rem=%h dz=%b busy=%b, want res=%h rem=%h dz=%b busy=0",
                 i, bus.result, bus.remainder, bus.divzero, bus.busy, e.res, e.rem, e.dz);
      else n_pass++;
      last_res = e.res;
      @(posedge clk); #1;
      n_total++;
      if (bus.done !== 1'b0) $display("FAIL add_done_pulse[%0d]: got done=%b, want 0", i, bus.done); else n_pass++;
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] av[2] = '{8'd10, 8'd20};
    logic [W-1:0] bv[2] = '{8'd20, 8'd10};
    int cyc;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(2'd1, av[i], bv[i], 1'b1);
      wait_done(cyc);
      e = sb.pop_front();
      n_total++;
      if (cyc !== 1) $display("FAIL sub_latency[%0d]: got %0d, want 1", i, cyc); else n_pass++;
      n_total++;
      if (bus.result !== e.res || bus.remainder !== e.rem || bus.divzero !== e.dz)
        $display("FAIL sub_result[%0d]: got res=%h rem=%h dz=%b, want res=%h rem=%h dz=%b",
                 i, bus.result, bus.remainder, bus.divzero, e.res, e.rem, e.dz);
      else n_pass++;
      last_res = e.res;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mult();
    int cyc;
    exp_t e;
    issue(2'd2, 8'd255, 8'd255, 1'b1);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 4*W) begin
      bus.start = (cyc == 2 || cyc == 4);
      bus.op = 2'd0; bus.a = 8'd1; bus.b = 8'd1;
      @(posedge clk); #1;
      cyc++;
      if (bus.done !== 1'b1 && cyc < W) begin
        n_total++;
        if (bus.busy !== 1'b1 || bus.result !== last_res)
          $display("FAIL mult_busy_hold[%0d]: got busy=%b res=%h, want busy=1 res=%h", cyc, bus.busy, bus.result, last_res);
        else n_pass++;
      end
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    n_total++;
    if (cyc !== W) $display("FAIL mult_latency: got %0d, want %0d", cyc, W); else n_pass++;
    n_total++;
    if (bus.result !== e.res || bus.remainder !== e.rem || bus.divzero !== e.dz || bus.busy !== 1'b0)
      $display("FAIL mult_result: got res=%h rem=%h dz=%b busy=%b, want res=%h rem=%h dz=%b busy=0",
               bus.result, bus.remainder, bus.divzero, bus.busy, e.res, e.rem, e.dz);
    else n_pass++;
    last_res = e.res;
    @(posedge clk); #1;
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL mult_no_queue: got busy=%b done=%b, want 0 0", bus.busy, bus.done);
    else n_pass++;
  endtask

  task automatic test_div();
    logic [1:0]   ov[4] = '{2'd3, 2'd3, 2'd0, 2'd3};
    logic [W-1:0] av[4] = '{8'd200, 8'd5, 8'd3, 8'd255};
    logic [W-1:0] bv[4] = '{8'd7, 8'd0, 8'd4, 8'd1};
    int           lv[4] = '{W, 1, 1, W};
    int cyc;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      issue(ov[i], av[i], bv[i], 1'b1);
      wait_done(cyc);
      e = sb.pop_front();
      n_total++;
      if (cyc !== lv[i]) $display("FAIL div_latency[%0d]: got %0d, want %0d", i, cyc, lv[i]); else n_pass++;
      n_total++;
      if (bus.result !== e.res || bus.remainder !== e.rem || bus.divzero !== e.dz)
        $display("FAIL div_result[%0d]: got res=%h rem=%h dz=%b, want res=%h rem=%h dz=%b",
                 i, bus.result, bus.remainder, bus.divzero, e.res, e.rem, e.dz);
      else n_pass++;
      last_res = e.res;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    exp_t e;
    issue(2'd2, 8'd200, 8'd100, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({bus.result, bus.remainder, bus.busy, bus.done, bus.divzero} !== '0)
      $display("FAIL midreset_clear: got res=%h rem=%h busy=%b done=%b dz=%b, want all 0",
               bus.result, bus.remainder, bus.busy, bus.done, bus.divzero);
    else n_pass++;
    repeat (W) begin
      @(posedge clk); #1;
      n_total++;
      if (bus.done !== 1'b0) $display("FAIL midreset_no_done: got done=%b, want 0", bus.done); else n_pass++;
    end
    rst_n = 1'b1;
    issue(2'd0, 8'd1, 8'd1, 1'b1);
    wait_done(cyc);
    e = sb.pop_front();
    n_total++;
    if (cyc !== 1 || bus.result !== e.res)
      $display("FAIL midreset_add: got lat=%0d res=%h, want lat=1 res=%h", cyc, bus.result, e.res);
    else n_pass++;
    last_res = e.res;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    exp_t e;
    bus.op = 2'd2; bus.a = 8'd3; bus.b = 8'd4; bus.start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(model(2'd2, 8'd3, 8'd4));
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      wait_done(cyc);
      e = sb.pop_front();
      n_total++;
      if (cyc !== W) $display("FAIL b2b_latency[%0d]: got %0d, want %0d", k, cyc, W); else n_pass++;
      n_total++;
      if (bus.result !== e.res || bus.busy !== 1'b0)
        $display("FAIL b2b_result[%0d]: got res=%h busy=%b, want res=%h busy=0", k, bus.result, bus.busy, e.res);
      else n_pass++;
      if (k == 2) bus.start = 1'b0;
      @(posedge clk); #1;
      n_total++;
      if (bus.busy !== (k < 2) || bus.done !== 1'b0)
        $display("FAIL b2b_restart[%0d]: got busy=%b done=%b, want busy=%b done=0", k, bus.busy, bus.done, (k < 2));
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mult();
    test_div();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
